// File: rtl/pipeline_writeback_if.sv
// Memory-stage to writeback handshake: one retiring instruction per accepted beat.
// Valid/ready: a beat transfers on a rising edge where mem_valid_i and mem_ready_o are both high.
interface pipeline_writeback_if;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i;
  logic [31:0] pc_plus4_i;
  logic [31:0] offset_i;

  modport master (
    output mem_valid_i, opcode_i, funct3_i, rd_i, alu_result_i, pc_plus4_i, offset_i,
    input  mem_ready_o
  );

  modport slave (
    input  mem_valid_i, opcode_i, funct3_i, rd_i, alu_result_i, pc_plus4_i, offset_i,
    output mem_ready_o
  );
endinterface

// File: rtl/pipeline_writeback.sv
// WB stage of the RV32I pipeline: selects the architectural result, extracts load data,
// drives the register-file write port, counts retirements and flags faulting loads.
module pipeline_writeback (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_writeback_if.slave   mem_if,
  input  logic                  dmem_rsp_valid_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic [4:0]            write_addr_reg_o,
  output logic [31:0]           write_data_reg_o,
  output logic                  reg_write_o,
  output logic                  retire_o,
  output logic                  load_fault_o,
  output logic [63:0]           instret_o,
  output logic                  dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  state_t      r_state, w_state_next;
  logic [4:0]  r_ld_rd;
  logic [2:0]  r_ld_f3;
  logic [1:0]  r_ld_addr;
  logic [4:0]  r_wr_addr, w_wr_addr_next;
  logic [31:0] r_wr_data, w_wr_data_next;
  logic        r_reg_write, w_reg_write_next;
  logic        r_retire, w_retire_next;
  logic        r_fault, w_fault_next;
  logic [63:0] r_instret;

  logic        w_accept;
  logic        w_is_load;
  logic        w_ld_bad;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  assign mem_if.mem_ready_o = (r_state == IDLE);
  assign w_accept  = mem_if.mem_valid_i & mem_if.mem_ready_o;
  assign w_is_load = (mem_if.opcode_i == OPC_LOAD);

  // Illegal widths first, then alignment of the legal halfword/word loads.
  always_comb begin
    w_ld_bad = 1'b0;
    case (mem_if.funct3_i)
      3'b011, 3'b110, 3'b111: w_ld_bad = 1'b1;
      3'b001, 3'b101:         w_ld_bad = mem_if.alu_result_i[0];
      3'b010:                 w_ld_bad = (mem_if.alu_result_i[1:0] != 2'b00);
      default:                w_ld_bad = 1'b0;
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata_i[7:0];
    case (r_ld_addr)
      2'd0:    w_byte = dmem_rdata_i[7:0];
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      default: w_byte = dmem_rdata_i[31:24];
    endcase
    w_half = r_ld_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_ld_f3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_wr_addr_next   = r_wr_addr;
    w_wr_data_next   = r_wr_data;
    w_reg_write_next = 1'b0;
    w_retire_next    = 1'b0;
    w_fault_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_load) begin
            if (w_ld_bad) w_fault_next = 1'b1;
            else          w_state_next = WAIT_LOAD;
          end else begin
            w_retire_next = 1'b1;
            case (mem_if.opcode_i)
              OPC_LUI: begin
                w_wr_addr_next   = mem_if.rd_i;
                w_wr_data_next   = mem_if.offset_i;
                w_reg_write_next = (mem_if.rd_i != 5'd0);
              end
              OPC_AUIPC, OPC_OP, OPC_OP_IMM: begin
                w_wr_addr_next   = mem_if.rd_i;
                w_wr_data_next   = mem_if.alu_result_i;
                w_reg_write_next = (mem_if.rd_i != 5'd0);
              end
              OPC_JAL, OPC_JALR: begin
                w_wr_addr_next   = mem_if.rd_i;
                w_wr_data_next   = mem_if.pc_plus4_i;
                w_reg_write_next = (mem_if.rd_i != 5'd0);
              end
              default: ;
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rsp_valid_i) begin
          w_state_next     = IDLE;
          w_wr_addr_next   = r_ld_rd;
          w_wr_data_next   = w_ld_data;
          w_reg_write_next = (r_ld_rd != 5'd0);
          w_retire_next    = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_wr_addr   <= 5'd0;
      r_wr_data   <= 32'd0;
      r_reg_write <= 1'b0;
      r_retire    <= 1'b0;
      r_fault     <= 1'b0;
      r_ld_rd     <= 5'd0;
      r_ld_f3     <= 3'd0;
      r_ld_addr   <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_wr_addr   <= w_wr_addr_next;
      r_wr_data   <= w_wr_data_next;
      r_reg_write <= w_reg_write_next;
      r_retire    <= w_retire_next;
      r_fault     <= w_fault_next;
      if (w_accept && w_is_load) begin
        r_ld_rd   <= mem_if.rd_i;
        r_ld_f3   <= mem_if.funct3_i;
        r_ld_addr <= mem_if.alu_result_i[1:0];
      end
    end
  end

  // Counter advances on the same edge that raises retire_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              r_instret <= 64'd0;
    else if (w_retire_next) r_instret <= r_instret + 64'd1;
  end

  assign write_addr_reg_o = r_wr_addr;
  assign write_data_reg_o = r_wr_data;
  assign reg_write_o      = r_reg_write;
  assign retire_o         = r_retire;
  assign load_fault_o     = r_fault;
  assign instret_o        = r_instret;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_pipeline_writeback.sv
// Randomized bench for pipeline_writeback against an instruction-level reference model.
module tb_pipeline_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        dmem_rsp_valid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  write_addr_reg_o;
  logic [31:0] write_data_reg_o;
  logic        reg_write_o;
  logic        retire_o;
  logic        load_fault_o;
  logic [63:0] instret_o;
  logic        dbg_state_o;

  pipeline_writeback_if ifc ();

  pipeline_writeback dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mem_if           (ifc.slave),
    .dmem_rsp_valid_i (dmem_rsp_valid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .write_addr_reg_o (write_addr_reg_o),
    .write_data_reg_o (write_data_reg_o),
    .reg_write_o      (reg_write_o),
    .retire_o         (retire_o),
    .load_fault_o     (load_fault_o),
    .instret_o        (instret_o),
    .dbg_state_o      (dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [63:0] exp_instret = '0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int load_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit load_faults(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = load_size(f3);
    if (sz == 0) return 1'b1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    int          sz;
    sz = load_size(f3);
    sh = rdata >> (8 * (addr % 4) - 8 * ((addr % 4) % sz));
    case (f3)
      3'b000:  return 32'($signed(sh << 24) >>> 24);
      3'b001:  return 32'($signed(sh << 16) >>> 16);
      3'b100:  return sh & 32'h0000_00FF;
      3'b101:  return sh & 32'h0000_FFFF;
      default: return rdata;
    endcase
  endfunction

  // 0: no register result, 1: offset, 2: alu, 3: link
  function automatic int result_kind(input logic [6:0] op);
    case (op)
      7'b0110111:                         return 1;
      7'b0010111, 7'b0110011, 7'b0010011: return 2;
      7'b1101111, 7'b1100111:             return 3;
      default:                            return 0;
    endcase
  endfunction

  task automatic check_outputs(input string tag, input bit e_wr, input bit e_ret, input bit e_flt);
    logic [31:0] d;
    d = exp_data;
    if (exp_q.size() != 0) d = exp_q.pop_front();
    check_eq({tag, "_wr"},      reg_write_o,      e_wr);
    check_eq({tag, "_ret"},     retire_o,         e_ret);
    check_eq({tag, "_fault"},   load_fault_o,     e_flt);
    check_eq({tag, "_addr"},    write_addr_reg_o, exp_addr);
    check_eq({tag, "_data"},    write_data_reg_o, d);
    check_eq({tag, "_instret"}, instret_o,        exp_instret);
    check_eq({tag, "_ready"},   ifc.mem_ready_o,  1'b1);
  endtask

  // driver: called at a falling edge, returns at the falling edge where the result is visible
  task automatic run_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] off, input int wait_cyc, input logic [31:0] rdata,
                         input bit early);
    int kind;
    check_eq({tag, "_ready_in"}, ifc.mem_ready_o, 1'b1);
    ifc.mem_valid_i  = 1'b1;
    ifc.opcode_i     = op;
    ifc.funct3_i     = f3;
    ifc.rd_i         = rd;
    ifc.alu_result_i = alu;
    ifc.pc_plus4_i   = pc4;
    ifc.offset_i     = off;
    dmem_rsp_valid_i = early;
    dmem_rdata_i     = ~rdata;
    @(negedge clk_i);
    ifc.mem_valid_i  = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    if (op == 7'b0000011) begin
      if (load_faults(f3, alu)) begin
        check_outputs({tag, "_flt"}, 1'b0, 1'b0, 1'b1);
      end else begin
        for (int i = 0; i < wait_cyc; i++) begin
          check_eq({tag, "_busy"}, ifc.mem_ready_o, 1'b0);
          check_eq({tag, "_wr_busy"}, reg_write_o | retire_o | load_fault_o, 1'b0);
          @(negedge clk_i);
        end
        check_eq({tag, "_busy_rsp"}, ifc.mem_ready_o, 1'b0);
        dmem_rsp_valid_i = 1'b1;
        dmem_rdata_i     = rdata;
        @(negedge clk_i);
        dmem_rsp_valid_i = 1'b0;
        exp_addr = rd;
        exp_data = load_value(f3, alu, rdata);
        exp_q.push_back(exp_data);
        exp_instret++;
        check_outputs({tag, "_ld"}, rd != 5'd0, 1'b1, 1'b0);
      end
    end else begin
      kind = result_kind(op);
      if (kind != 0) begin
        exp_addr = rd;
        exp_data = (kind == 1) ? off : (kind == 2) ? alu : pc4;
      end
      exp_q.push_back(exp_data);
      exp_instret++;
      check_outputs({tag, "_nl"}, (kind != 0) && (rd != 5'd0), 1'b1, 1'b0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      dmem_rsp_valid_i = 1'($urandom_range(0, 1));
      dmem_rdata_i     = $urandom;
      @(negedge clk_i);
      check_eq("idle_strobes", reg_write_o | retire_o | load_fault_o, 1'b0);
      check_eq("idle_ready", ifc.mem_ready_o, 1'b1);
    end
    dmem_rsp_valid_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"},   ifc.mem_ready_o, 1'b1);
    check_eq({tag, "_wr"},      reg_write_o,     1'b0);
    check_eq({tag, "_ret"},     retire_o,        1'b0);
    check_eq({tag, "_fault"},   load_fault_o,    1'b0);
    check_eq({tag, "_addr"},    write_addr_reg_o, 5'd0);
    check_eq({tag, "_data"},    write_data_reg_o, 32'd0);
    check_eq({tag, "_instret"}, instret_o,       64'd0);
  endtask

  logic [6:0] op_tab [11] = '{7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011, 7'b1101111,
                              7'b1100111, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1110011};

  initial begin
    ifc.mem_valid_i  = 1'b0;
    ifc.opcode_i     = '0;
    ifc.funct3_i     = '0;
    ifc.rd_i         = '0;
    ifc.alu_result_i = '0;
    ifc.pc_plus4_i   = '0;
    ifc.offset_i     = '0;
    dmem_rsp_valid_i = 1'b0;
    dmem_rdata_i     = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_state("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // directed cases
    run_txn("addi", 7'b0010011, 3'b000, 5'd5, 32'h0000_0123, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    check_eq("addi_instret1", instret_o, 64'd1);
    run_txn("lb",  7'b0000011, 3'b000, 5'd7, 32'h0000_1003, 32'h0, 32'h0, 2, 32'h80FF_0000, 1'b0);
    check_eq("lb_val", write_data_reg_o, 32'hFFFF_FF80);
    run_txn("lbu", 7'b0000011, 3'b100, 5'd7, 32'h0000_1003, 32'h0, 32'h0, 2, 32'h80FF_0000, 1'b0);
    check_eq("lbu_val", write_data_reg_o, 32'h0000_0080);
    run_txn("lh_mis", 7'b0000011, 3'b001, 5'd3, 32'h0000_2001, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    idle_cycles(1);
    run_txn("jal_x0", 7'b1101111, 3'b000, 5'd0, 32'h0, 32'h0000_1004, 32'h0, 0, 32'h0, 1'b0);
    run_txn("lui", 7'b0110111, 3'b000, 5'd1, 32'h0, 32'h0, 32'hABCD_E000, 0, 32'h0, 1'b0);
    check_eq("lui_val", write_data_reg_o, 32'hABCD_E000);
    run_txn("early", 7'b0000011, 3'b101, 5'd9, 32'h0000_0042, 32'h0, 32'h0, 0, 32'h1234_8765, 1'b1);
    run_txn("lw_ill", 7'b0000011, 3'b110, 5'd4, 32'h0000_0040, 32'h0, 32'h0, 0, 32'h0, 1'b0);

    // reset while a load is outstanding; the late response must be ignored
    ifc.mem_valid_i  = 1'b1;
    ifc.opcode_i     = 7'b0000011;
    ifc.funct3_i     = 3'b010;
    ifc.rd_i         = 5'd12;
    ifc.alu_result_i = 32'h0000_0100;
    @(negedge clk_i);
    ifc.mem_valid_i = 1'b0;
    check_eq("rstw_busy", ifc.mem_ready_o, 1'b0);
    rst_i = 1'b1;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_instret = '0;
    exp_q.delete();
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i     = 32'hDEAD_BEEF;
    @(negedge clk_i);
    dmem_rsp_valid_i = 1'b0;
    check_reset_state("late_rsp");
    run_txn("post_rst", 7'b0110011, 3'b000, 5'd2, 32'h0000_0777, 32'h0, 32'h0, 0, 32'h0, 1'b0);

    // randomized traffic, back-to-back and with gaps
    for (int n = 0; n < 300; n++) begin
      logic [6:0]  op;
      logic [31:0] alu;
      op  = op_tab[$urandom_range(0, 10)];
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      run_txn("rnd", op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), alu,
              $urandom, $urandom, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    // counter wrap from all-ones
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    check_eq("preload", instret_o, exp_instret);
    run_txn("wrap", 7'b0100011, 3'b010, 5'd6, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    check_eq("wrap_zero", instret_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
